// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the imem request handshake and
// fills the IF/ID register, with stall, redirect flush and a one-word hold buffer.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic [5:0]  id_op,
  output logic        id_valid
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_DROP} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] hold_instr;
  logic [31:0] hold_pc4;
  logic [31:0] pending_target;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic [31:0] redirect_target;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;
  assign id_op     = id_instr[31:26];

  // Only an instruction actually sitting in ID may redirect; jr wins, then jump.
  always_comb begin
    redirect        = id_valid & (jr | jump | branch_taken);
    redirect_target = branch_target;
    if (jr)
      redirect_target = jr_target;
    else if (jump)
      redirect_target = {id_pc_plus4[31:28], id_instr[25:0], 2'b00};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      pc             <= RESET_PC;
      imem_req       <= 1'b0;
      id_instr       <= 32'h0;
      id_pc_plus4    <= 32'h0;
      id_valid       <= 1'b0;
      hold_instr     <= 32'h0;
      hold_pc4       <= 32'h0;
      pending_target <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          state    <= S_FETCH;
          imem_req <= 1'b1;
        end

        S_FETCH: begin
          if (redirect) begin
            id_valid   <= 1'b0;
            id_instr   <= 32'h0;
            hold_instr <= 32'h0;
            hold_pc4   <= 32'h0;
            if (imem_ready) begin
              pc <= redirect_target;
            end else begin
              // Address must stay put until the outstanding request is accepted.
              pending_target <= redirect_target;
              state          <= S_DROP;
            end
          end else if (imem_ready) begin
            pc <= pc_plus4;
            if (stall) begin
              hold_instr <= imem_rdata;
              hold_pc4   <= pc_plus4;
              imem_req   <= 1'b0;
              state      <= S_HOLD;
            end else begin
              id_instr    <= imem_rdata;
              id_pc_plus4 <= pc_plus4;
              id_valid    <= 1'b1;
            end
          end
        end

        S_HOLD: begin
          if (redirect) begin
            id_valid   <= 1'b0;
            id_instr   <= 32'h0;
            hold_instr <= 32'h0;
            hold_pc4   <= 32'h0;
            pc         <= redirect_target;
            imem_req   <= 1'b1;
            state      <= S_FETCH;
          end else if (!stall) begin
            id_instr    <= hold_instr;
            id_pc_plus4 <= hold_pc4;
            id_valid    <= 1'b1;
            hold_instr  <= 32'h0;
            hold_pc4    <= 32'h0;
            imem_req    <= 1'b1;
            state       <= S_FETCH;
          end
        end

        S_DROP: begin
          if (redirect) begin
            id_valid       <= 1'b0;
            id_instr       <= 32'h0;
            pending_target <= redirect_target;
          end
          if (imem_ready) begin
            pc    <= redirect ? redirect_target : pending_target;
            state <= S_FETCH;
          end
        end

        default: begin
          state    <= S_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the MIPS pipeline, directly upstream of the main control decoder.
- Holds the PC and drives the instruction-memory request handshake.
- Applies branch/jump/jr redirects and fills the IF/ID pipeline register. The decoder reads `id_op` from this register.
- Supports stall (hazard unit) and flush (redirect), and buffers one word when memory returns data during a stall.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  hazard unit: hold IF/ID and PC
branch_taken  in  1  beq/bne resolved taken (Branch & condition)
branch_target  in  32  branch destination
jump  in  1  j/jal in ID
jr  in  1  jr in ID
jr_target  in  32  register value for jr
imem_req  out  1  fetch request (registered)
imem_addr  out  32  fetch address = pc
imem_ready  in  1  memory accepts the request; imem_rdata valid this cycle
imem_rdata  in  32  fetched word
id_instr  out  32  IF/ID instruction
id_pc_plus4  out  32  IF/ID PC+4
id_op  out  6  id_instr[31:26], feeds control decoder
id_valid  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=S_IDLE, imem_req=0.
  - id_instr=0 (nop), id_pc_plus4=0, id_valid=0, hold buffer empty.
- States:
  - S_IDLE: the next edge goes to S_FETCH and sets imem_req=1.
  - S_FETCH: imem_req=1, imem_addr=pc. On an edge with imem_ready=1, the fetch completes.
  - S_HOLD: imem_req=0. The fetched word is parked in hold_instr/hold_pc4.
  - S_DROP: a redirect arrived while a request was outstanding. imem_req stays 1 and the address stays stable until imem_ready. The returned word is discarded. Then pc=pending_target and the next state is S_FETCH.
- Handshake rule: imem_addr must not change while imem_req=1 and imem_ready=0.
- Redirect target priority: jr > jump > branch_taken.
  - jr target = jr_target.
  - jump target = {id_pc_plus4[31:28], id_instr[25:0], 2'b00}.
  - branch target = branch_target.
  - A redirect is valid only when id_valid=1.
- Redirect outranks stall. On a redirect edge:
  - id_valid<=0 and id_instr<=0 (flush the delay slot).
  - Hold buffer is cleared.
  - If in S_FETCH with imem_ready=1: the word is discarded, pc<=target, state stays S_FETCH.
  - If in S_FETCH with imem_ready=0: pending_target<=target, go to S_DROP.
  - If in S_HOLD: pc<=target, go to S_FETCH.
- A redirect while in S_DROP overwrites pending_target.
- Normal completion (S_FETCH, imem_ready=1, no stall, no redirect): id_instr<=imem_rdata, id_pc_plus4<=pc+4, id_valid<=1, pc<=pc+4.
  - Zero-wait memory gives one instruction per cycle.
  - IF/ID latency is 1 edge after the request address is presented.
- Completion with stall=1: IF/ID holds. hold_instr<=imem_rdata, hold_pc4<=pc+4, pc<=pc+4, go to S_HOLD.
- S_HOLD, stall=0: IF/ID<=hold buffer, id_valid<=1, go to S_FETCH.
- Stall in S_FETCH without imem_ready: IF/ID and pc hold; the request stays asserted.
- PC arithmetic is modulo 2^32: pc=32'hFFFF_FFFC wraps to 0.
- id_op is always id_instr[31:26]; it is 0 (R-type nop) after flush or reset.
- When rst_n asserts mid-transaction, the outstanding request is abandoned. After release, fetch restarts at RESET_PC.

Test Plan:
- Reset release, imem_ready tied 1, mem[i]=i*4+32'h1000 → imem_addr 0,4,8 on consecutive cycles; id_instr=32'h1000,32'h1004,…; id_valid rises on the 2nd edge after release.
- imem_ready low 3 cycles at addr 8 → imem_addr stays 8 and id_valid=1 holding the previous word; id_instr updates on the edge when ready=1.
- stall=1 for 2 cycles while the word at 12 returns → state S_HOLD, imem_req=0, id_instr unchanged; after stall drops, id_instr=word@12 and the next fetch is at 16.
- jump with id_pc_plus4=32'h4000_0010 and id_instr[25:0]=26'h0000040 → next imem_addr=32'h4000_0100, id_valid=0 for one cycle.
- branch_taken (target 32'h200) while the request at 24 waits on ready → S_DROP; the returned word is discarded, the next address is 32'h200, and the discarded word never appears in id_instr.
- jr and branch_taken together, jr_target=32'h80 → next address 32'h80; rst_n pulsed low mid-S_DROP → imem_req=0 and pc=RESET_PC immediately.
